mem_arbiter: RTL

- Arbitrates a single-port unified instruction/data memory between the fetch stage and the memory stage of the 5-stage pipeline.
- Sequences the memory-side request/acknowledge handshake.
- Returns read data to the winning requester and raises per-stage stall signals to the pipeline control path, alongside the hazard unit's STALL/FLUSH.
- Data accesses have priority; a starvation counter bounds fetch wait.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_starve_ctr.sv | 30 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified I/D memory arbiter: FSM states and the
// requester-select encoding used to steer the memory port.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef logic port_sel_t;

  localparam port_sel_t SEL_I = 1'b0;
  localparam port_sel_t SEL_D = 1'b1;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating counter of consecutive data grants taken while fetch waits;
// o_sat tells the arbiter that fetch must win the next decision.
module mem_arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int unsigned W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and MEM stage: data has priority,
// a starvation counter bounds how long fetch can be held off.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IF_REQ,
  input  logic [ADDR_W-1:0]   IF_ADDR,
  output logic [DATA_W-1:0]   IF_RDATA,
  output logic                IF_VALID,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  input  logic [DATA_W/8-1:0] D_BE,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                D_VALID,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_WDATA,
  output logic [DATA_W/8-1:0] MEM_BE,
  input  logic                MEM_ACK,
  input  logic [DATA_W-1:0]   MEM_RDATA,
  output logic                STALL_IF,
  output logic                STALL_MEM,
  output logic                SPURIOUS_ACK
);

  arb_state_t r_state;
  arb_state_t w_next;
  port_sel_t  w_sel;
  logic       r_spurious;
  logic       w_decide;
  logic       w_pick_d;
  logic       w_pick_i;
  logic       w_sat;
  logic       w_inc;
  logic       w_clr;

  // A decision is taken when idle or when the current access completes,
  // so back-to-back grants need no idle cycle.
  assign w_decide = (r_state == IDLE) || MEM_ACK;
  assign w_pick_d = D_REQ && !(IF_REQ && w_sat);
  assign w_pick_i = !w_pick_d && IF_REQ;
  assign w_inc    = w_decide && w_pick_d && IF_REQ;
  assign w_clr    = w_decide && (w_pick_i || !IF_REQ);

  mem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_sat (w_sat)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_decide) begin
      if (w_pick_d) begin
        w_next = GNT_D;
      end else if (w_pick_i) begin
        w_next = GNT_I;
      end else begin
        w_next = IDLE;
      end
    end
  end

  // An ACK with nothing outstanding (including one for an access aborted by reset).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_spurious <= 1'b0;
    end else if ((r_state == IDLE) && MEM_ACK) begin
      r_spurious <= 1'b1;
    end
  end

  assign SPURIOUS_ACK = r_spurious;

  always_comb begin
    w_sel     = (r_state == GNT_D) ? SEL_D : SEL_I;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    MEM_BE    = '0;
    IF_VALID  = 1'b0;
    D_VALID   = 1'b0;
    IF_RDATA  = '0;
    D_RDATA   = '0;
    if (r_state != IDLE) begin
      MEM_REQ = 1'b1;
      if (w_sel == SEL_D) begin
        MEM_WE    = D_WE;
        MEM_ADDR  = D_ADDR;
        MEM_WDATA = D_WDATA;
        MEM_BE    = D_BE;
        D_VALID   = MEM_ACK;
        D_RDATA   = MEM_ACK ? MEM_RDATA : '0;
      end else begin
        MEM_ADDR  = IF_ADDR;
        MEM_BE    = '1;
        IF_VALID  = MEM_ACK;
        IF_RDATA  = MEM_ACK ? MEM_RDATA : '0;
      end
    end
    STALL_IF  = IF_REQ && !IF_VALID;
    STALL_MEM = D_REQ && !D_VALID;
  end

endmodule
